// File: rtl/spram_mem_ctrl.sv
// Load/store controller for a pair of SB_SPRAM256KA macros (16K x 32 data memory).
// Registered outputs, one outstanding request, idle-timeout sleep with timed wake.
module spram_mem_ctrl #(
  parameter logic [31:0] BASE_ADDR    = 32'h0001_0000,
  parameter int unsigned IDLE_TIMEOUT = 256,
  parameter int unsigned WAKE_CYCLES  = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_be,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [13:0] spram_address,
  output logic [15:0] spram_datain_lo,
  output logic [15:0] spram_datain_hi,
  output logic [3:0]  spram_maskwren_lo,
  output logic [3:0]  spram_maskwren_hi,
  output logic        spram_wren,
  output logic        spram_cs,
  output logic        spram_standby,
  output logic        spram_sleep,
  output logic        spram_poweroff,
  input  logic [15:0] spram_dataout_lo,
  input  logic [15:0] spram_dataout_hi
);

  localparam int unsigned CNT_W  = $clog2(IDLE_TIMEOUT + 2);
  localparam int unsigned WAKE_W = $clog2(WAKE_CYCLES + 1);
  localparam logic [CNT_W-1:0]  IDLE_MAX  = CNT_W'(IDLE_TIMEOUT);
  localparam logic [WAKE_W-1:0] WAKE_LAST = WAKE_W'(WAKE_CYCLES - 1);
  localparam bit SLEEP_EN = (IDLE_TIMEOUT != 0);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ACCESS,
    ST_CAPTURE,
    ST_SLEEP,
    ST_WAKE
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  idle_cnt_q, idle_cnt_d;
  logic [WAKE_W-1:0] wake_cnt_q, wake_cnt_d;

  logic        accept, addr_err;
  logic        req_ready_d, resp_valid_d, resp_err_d;
  logic [31:0] resp_rdata_d;
  logic [13:0] address_d;
  logic [15:0] datain_lo_d, datain_hi_d;
  logic [3:0]  mask_lo_d, mask_hi_d;
  logic        wren_d, cs_d, sleep_d;

  assign spram_standby  = 1'b0;
  assign spram_poweroff = 1'b1;

  always_comb begin
    accept   = req_valid && req_ready;
    addr_err = (req_addr[31:16] != BASE_ADDR[31:16]) || (req_addr[1:0] != 2'b00);

    state_d      = state_q;
    idle_cnt_d   = idle_cnt_q;
    wake_cnt_d   = '0;
    resp_valid_d = 1'b0;
    resp_err_d   = 1'b0;
    resp_rdata_d = resp_rdata;
    address_d    = spram_address;
    datain_lo_d  = spram_datain_lo;
    datain_hi_d  = spram_datain_hi;
    mask_lo_d    = spram_maskwren_lo;
    mask_hi_d    = spram_maskwren_hi;
    wren_d       = 1'b0;
    cs_d         = 1'b0;
    sleep_d      = spram_sleep;

    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          idle_cnt_d = '0;
          if (addr_err) begin
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b1;
            resp_rdata_d = '0;
          end else begin
            state_d   = ST_ACCESS;
            cs_d      = 1'b1;
            wren_d    = req_we;
            address_d = req_addr[15:2];
            if (req_we) begin
              datain_lo_d = req_wdata[15:0];
              datain_hi_d = req_wdata[31:16];
              mask_lo_d   = {{2{req_be[1]}}, {2{req_be[0]}}};
              mask_hi_d   = {{2{req_be[3]}}, {2{req_be[2]}}};
            end else begin
              mask_lo_d = '0;
              mask_hi_d = '0;
            end
          end
        end else if (!req_valid) begin
          if (idle_cnt_q != IDLE_MAX) idle_cnt_d = idle_cnt_q + CNT_W'(1);
          if (SLEEP_EN && (idle_cnt_d == IDLE_MAX)) begin
            state_d = ST_SLEEP;
            sleep_d = 1'b1;
          end
        end
      end
      ST_ACCESS: begin
        // spram_wren still carries the direction of the access being issued
        if (spram_wren) begin
          state_d      = ST_IDLE;
          resp_valid_d = 1'b1;
          resp_rdata_d = '0;
        end else begin
          state_d = ST_CAPTURE;
        end
      end
      ST_CAPTURE: begin
        state_d      = ST_IDLE;
        resp_valid_d = 1'b1;
        resp_rdata_d = {spram_dataout_hi, spram_dataout_lo};
      end
      ST_SLEEP: begin
        idle_cnt_d = '0;
        if (req_valid) begin
          state_d = ST_WAKE;
          sleep_d = 1'b0;
        end
      end
      ST_WAKE: begin
        idle_cnt_d = '0;
        if (wake_cnt_q == WAKE_LAST) begin
          state_d = ST_IDLE;
        end else begin
          wake_cnt_d = wake_cnt_q + WAKE_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    req_ready_d = (state_d == ST_IDLE) && !resp_valid_d;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q           <= ST_IDLE;
      idle_cnt_q        <= '0;
      wake_cnt_q        <= '0;
      req_ready         <= 1'b0;
      resp_valid        <= 1'b0;
      resp_err          <= 1'b0;
      resp_rdata        <= '0;
      spram_address     <= '0;
      spram_datain_lo   <= '0;
      spram_datain_hi   <= '0;
      spram_maskwren_lo <= '0;
      spram_maskwren_hi <= '0;
      spram_wren        <= 1'b0;
      spram_cs          <= 1'b0;
      spram_sleep       <= 1'b0;
    end else begin
      state_q           <= state_d;
      idle_cnt_q        <= idle_cnt_d;
      wake_cnt_q        <= wake_cnt_d;
      req_ready         <= req_ready_d;
      resp_valid        <= resp_valid_d;
      resp_err          <= resp_err_d;
      resp_rdata        <= resp_rdata_d;
      spram_address     <= address_d;
      spram_datain_lo   <= datain_lo_d;
      spram_datain_hi   <= datain_hi_d;
      spram_maskwren_lo <= mask_lo_d;
      spram_maskwren_hi <= mask_hi_d;
      spram_wren        <= wren_d;
      spram_cs          <= cs_d;
      spram_sleep       <= sleep_d;
    end
  end

endmodule

// File: tb/tb_spram_mem_ctrl.sv
// Scoreboard bench for spram_mem_ctrl: directed scenarios followed by random traffic,
// with a behavioural SPRAM pair and a word-level reference memory.
module tb_spram_mem_ctrl;

  localparam logic [31:0] BASE = 32'h0001_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_we;
  logic [31:0] req_addr, req_wdata;
  logic [3:0]  req_be;
  logic        resp_valid, resp_err;
  logic [31:0] resp_rdata;
  logic [13:0] spram_address;
  logic [15:0] spram_datain_lo, spram_datain_hi;
  logic [3:0]  spram_maskwren_lo, spram_maskwren_hi;
  logic        spram_wren, spram_cs, spram_standby, spram_sleep, spram_poweroff;
  logic [15:0] spram_dataout_lo, spram_dataout_hi;

  spram_mem_ctrl #(
    .BASE_ADDR    (BASE),
    .IDLE_TIMEOUT (8),
    .WAKE_CYCLES  (4)
  ) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .req_valid         (req_valid),
    .req_ready         (req_ready),
    .req_we            (req_we),
    .req_addr          (req_addr),
    .req_wdata         (req_wdata),
    .req_be            (req_be),
    .resp_valid        (resp_valid),
    .resp_rdata        (resp_rdata),
    .resp_err          (resp_err),
    .spram_address     (spram_address),
    .spram_datain_lo   (spram_datain_lo),
    .spram_datain_hi   (spram_datain_hi),
    .spram_maskwren_lo (spram_maskwren_lo),
    .spram_maskwren_hi (spram_maskwren_hi),
    .spram_wren        (spram_wren),
    .spram_cs          (spram_cs),
    .spram_standby     (spram_standby),
    .spram_sleep       (spram_sleep),
    .spram_poweroff    (spram_poweroff),
    .spram_dataout_lo  (spram_dataout_lo),
    .spram_dataout_hi  (spram_dataout_hi)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // Behavioural SPRAM pair: registered read, nibble-masked write, garbage while asleep or writing.
  logic [15:0] mem_lo [16384];
  logic [15:0] mem_hi [16384];

  initial begin
    for (int i = 0; i < 16384; i++) begin
      mem_lo[i] = '0;
      mem_hi[i] = '0;
    end
    spram_dataout_lo = '0;
    spram_dataout_hi = '0;
  end

  always @(posedge clk) begin
    logic [15:0] wlo, whi;
    if (spram_sleep) begin
      spram_dataout_lo <= 16'($urandom);
      spram_dataout_hi <= 16'($urandom);
    end else if (spram_cs && spram_poweroff) begin
      if (spram_wren) begin
        wlo = mem_lo[spram_address];
        whi = mem_hi[spram_address];
        for (int n = 0; n < 4; n++) begin
          if (spram_maskwren_lo[n]) wlo[n*4 +: 4] = spram_datain_lo[n*4 +: 4];
          if (spram_maskwren_hi[n]) whi[n*4 +: 4] = spram_datain_hi[n*4 +: 4];
        end
        mem_lo[spram_address] <= wlo;
        mem_hi[spram_address] <= whi;
        spram_dataout_lo <= 16'($urandom);
        spram_dataout_hi <= 16'($urandom);
      end else begin
        spram_dataout_lo <= mem_lo[spram_address];
        spram_dataout_hi <= mem_hi[spram_address];
      end
    end
  end

  // Reference model: byte-addressed word memory plus expected event queues.
  logic [31:0] ref_mem [16384];

  typedef struct {
    int          at;
    logic        err;
    logic [31:0] rdata;
  } resp_t;

  typedef struct {
    int          at;
    logic        we;
    logic [13:0] addr;
    logic [3:0]  mlo;
    logic [3:0]  mhi;
    logic [31:0] data;
  } acc_t;

  resp_t rq[$];
  acc_t  aq[$];

  initial for (int i = 0; i < 16384; i++) ref_mem[i] = '0;

  task automatic model(input logic we, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] be, input bit exp_resp);
    bit          in_window;
    int          word;
    logic [7:0]  m;
    logic [31:0] w;
    resp_t       r;
    acc_t        x;
    in_window = (a >= BASE) && (a - BASE < 32'h1_0000) && (a % 4 == 0);
    if (!in_window) begin
      r.at = cyc + 1; r.err = 1'b1; r.rdata = '0;
      if (exp_resp) rq.push_back(r);
      return;
    end
    word = int'((a - BASE) / 4);
    m = '0;
    w = ref_mem[word];
    if (we) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) begin
          m[2*b +: 2] = 2'b11;
          w[8*b +: 8] = d[8*b +: 8];
        end
      end
      ref_mem[word] = w;
    end
    x.at = cyc + 1; x.we = we; x.addr = 14'(word); x.mlo = m[3:0]; x.mhi = m[7:4]; x.data = d;
    aq.push_back(x);
    r.at = we ? cyc + 2 : cyc + 3;
    r.err = 1'b0;
    r.rdata = we ? 32'h0 : ref_mem[word];
    if (exp_resp) rq.push_back(r);
  endtask

  // Monitor: compares DUT activity against queued expectations, sampled mid-cycle.
  always @(negedge clk) begin
    resp_t r;
    acc_t  x;
    if (resp_valid) begin
      chk("resp_expected", 64'(rq.size() != 0), 64'd1);
      if (rq.size() != 0) begin
        r = rq.pop_front();
        chk("resp_time", 64'(cyc), 64'(r.at));
        chk("resp_err", 64'(resp_err), 64'(r.err));
        chk("resp_rdata", 64'(resp_rdata), 64'(r.rdata));
      end
    end else if (rq.size() != 0 && rq[0].at < cyc) begin
      chk("resp_missing", 64'(cyc), 64'(rq[0].at));
      void'(rq.pop_front());
    end
    if (spram_cs) begin
      chk("cs_expected", 64'(aq.size() != 0), 64'd1);
      chk("cs_while_sleep", 64'(spram_sleep), 64'd0);
      if (aq.size() != 0) begin
        x = aq.pop_front();
        chk("cs_time", 64'(cyc), 64'(x.at));
        chk("wren", 64'(spram_wren), 64'(x.we));
        chk("address", 64'(spram_address), 64'(x.addr));
        chk("mask_lo", 64'(spram_maskwren_lo), 64'(x.mlo));
        chk("mask_hi", 64'(spram_maskwren_hi), 64'(x.mhi));
        if (x.we) chk("datain", 64'({spram_datain_hi, spram_datain_lo}), 64'(x.data));
      end
    end else if (aq.size() != 0 && aq[0].at < cyc) begin
      chk("cs_missing", 64'(cyc), 64'(aq[0].at));
      void'(aq.pop_front());
    end
    if (spram_wren) chk("wren_needs_cs", 64'(spram_cs), 64'd1);
  end

  // Called at a negedge; leaves req_valid high at the negedge after the accepting edge.
  task automatic issue(input logic we, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] be, input bit exp_resp, output int waited);
    req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = d; req_be = be;
    waited = 0;
    while (!req_ready && waited < 64) begin
      @(negedge clk);
      waited++;
    end
    if (!req_ready) begin
      chk("accept_timeout", 64'(req_ready), 64'd1);
      req_valid = 1'b0;
      return;
    end
    model(we, a, d, be, exp_resp);
    @(negedge clk);
  endtask

  task automatic drain();
    int n = 0;
    req_valid = 1'b0;
    while ((rq.size() != 0 || aq.size() != 0) && n < 64) begin
      @(negedge clk);
      n++;
    end
    if (rq.size() != 0 || aq.size() != 0) begin
      chk("drain_timeout", 64'(rq.size() + aq.size()), 64'd0);
      rq.delete();
      aq.delete();
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_req_ready"},  64'(req_ready), 64'd0);
    chk({tag, "_resp_valid"}, 64'(resp_valid), 64'd0);
    chk({tag, "_resp_rdata"}, 64'(resp_rdata), 64'd0);
    chk({tag, "_resp_err"},   64'(resp_err), 64'd0);
    chk({tag, "_cs"},         64'(spram_cs), 64'd0);
    chk({tag, "_wren"},       64'(spram_wren), 64'd0);
    chk({tag, "_address"},    64'(spram_address), 64'd0);
    chk({tag, "_datain"},     64'({spram_datain_hi, spram_datain_lo}), 64'd0);
    chk({tag, "_masks"},      64'({spram_maskwren_hi, spram_maskwren_lo}), 64'd0);
    chk({tag, "_sleep"},      64'(spram_sleep), 64'd0);
    chk({tag, "_standby"},    64'(spram_standby), 64'd0);
    chk({tag, "_poweroff"},   64'(spram_poweroff), 64'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int w, w1, w2, gap, kind, word;
    logic [31:0] a;

    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0;
    req_addr = '0; req_wdata = '0; req_be = '0;
    repeat (2) @(negedge clk);
    check_reset_outputs("por");
    rst_n = 1'b1;
    @(negedge clk);

    // Full-word store then load, partial store then reload
    issue(1'b1, 32'h0001_0010, 32'hDEAD_BEEF, 4'b1111, 1'b1, w);
    drain();
    issue(1'b0, 32'h0001_0010, 32'h0, 4'b0000, 1'b1, w);
    drain();
    issue(1'b1, 32'h0001_0010, 32'h0000_5500, 4'b0010, 1'b1, w);
    drain();
    issue(1'b0, 32'h0001_0010, 32'h0, 4'b0000, 1'b1, w);
    drain();

    // Window and alignment errors, and a be=0 store that must not modify memory
    issue(1'b0, 32'h0002_0000, 32'h0, 4'b0000, 1'b1, w);
    drain();
    issue(1'b1, 32'h0001_0002, 32'h1234_5678, 4'b1111, 1'b1, w);
    drain();
    issue(1'b1, 32'h0001_0010, 32'h1111_1111, 4'b0000, 1'b1, w);
    drain();

    // Back-to-back loads with req_valid held
    issue(1'b0, 32'h0001_0010, 32'h0, 4'b0000, 1'b1, w);
    issue(1'b0, 32'h0001_0010, 32'h0, 4'b0000, 1'b1, w1);
    issue(1'b0, 32'h0001_0014, 32'h0, 4'b0000, 1'b1, w2);
    chk("b2b_spacing_1", 64'(w1 + 1), 64'd4);
    chk("b2b_spacing_2", 64'(w2 + 1), 64'd4);
    drain();

    // Reset while the load sits in CAPTURE: response dropped
    issue(1'b0, 32'h0001_0010, 32'h0, 4'b0000, 1'b0, w);
    req_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check_reset_outputs("midrst");
    rst_n = 1'b1;

    // Idle timeout into SLEEP, then wake on demand
    repeat (7) @(negedge clk);
    chk("sleep_before_timeout", 64'(spram_sleep), 64'd0);
    @(negedge clk);
    chk("sleep_at_timeout", 64'(spram_sleep), 64'd1);
    chk("ready_in_sleep", 64'(req_ready), 64'd0);
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h0001_0010; req_be = 4'b0000;
    @(negedge clk);
    chk("wake_sleep_drop", 64'(spram_sleep), 64'd0);
    for (int i = 0; i < 4; i++) begin
      chk("wake_ready_low", 64'(req_ready), 64'd0);
      @(negedge clk);
    end
    chk("wake_ready_high", 64'(req_ready), 64'd1);
    issue(1'b0, 32'h0001_0010, 32'h0, 4'b0000, 1'b1, w);
    drain();

    // Random traffic over a small set of words, with occasional long gaps
    for (int t = 0; t < 200; t++) begin
      kind = int'($urandom_range(0, 19));
      word = int'($urandom_range(0, 31));
      a = BASE + 32'(word * 4);
      if (kind == 0) begin
        a = $urandom;
        if (a[31:16] == BASE[31:16]) a[31:16] = ~a[31:16];
      end else if (kind == 1) begin
        a = a + 32'($urandom_range(1, 3));
      end
      issue(1'($urandom), a, $urandom, 4'($urandom), 1'b1, w);
      gap = ($urandom_range(0, 9) == 0) ? int'($urandom_range(8, 14)) : int'($urandom_range(0, 3));
      if (gap != 0) begin
        req_valid = 1'b0;
        repeat (gap) @(negedge clk);
      end
    end
    drain();
    repeat (4) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
